// File: rtl/frac_interp_ctrl.sv
// Output-driven control for a single-MAC polyphase fractional interpolator (L/M rate change).
// Define FRAC_INTERP_OVERRUN_EN to build the sticky request-overrun flag; otherwise Overrun_o is tied 0.
module frac_interp_ctrl #(
    parameter int FilterLength   = 16,
    parameter int InterpolationK = 3,
    parameter int DecimationK    = 2,
    parameter int AddrW          = 4
) (
    input  logic             Rst_i,
    input  logic             Clk_i,
    input  logic             OutReq_i,
    output logic             DataReq_o,
    input  logic             DataNd_i,
    output logic             DataWe_o,
    output logic [AddrW-1:0] DataAddrWr_o,
    output logic [AddrW-1:0] DataAddr_o,
    output logic [AddrW-1:0] CoeffAddr_o,
    output logic             StartAcc_o,
    output logic             DataValid_o,
    output logic             Busy_o,
    output logic             Overrun_o
);
    localparam logic [AddrW:0]   LP_L_SUM  = (AddrW+1)'(InterpolationK);
    localparam logic [AddrW:0]   LP_M_SUM  = (AddrW+1)'(DecimationK);
    localparam logic [AddrW-1:0] LP_L_ADDR = AddrW'(InterpolationK);
    localparam logic [AddrW+1:0] LP_L_CMP  = (AddrW+2)'(InterpolationK);
    localparam logic [AddrW+1:0] LP_FL_CMP = (AddrW+2)'(FilterLength);
    localparam logic [AddrW-1:0] LP_ONE    = {{(AddrW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_WORK = 2'd2
    } state_t;

    state_t           r_state;
    logic [AddrW-1:0] r_addr_wr;
    logic [AddrW-1:0] r_data_addr;
    logic [AddrW-1:0] r_coeff_addr;
    logic [AddrW-1:0] r_phase;
    logic             r_pending;
    logic             r_req_latch;
    logic             r_rdy;
    logic             r_start_acc;
    logic [1:0]       r_start_sr;
    logic [1:0]       r_rdy_sr;

    logic [AddrW:0]   w_sum;
    logic             w_wrap;
    logic [AddrW-1:0] w_phase_next;
    logic             w_more_taps;
    logic             w_req;
    logic             w_launch;
    logic [AddrW-1:0] w_newest;

    // sum < 2L, so a single conditional subtract is a full modulo-L reduction
    assign w_sum        = {1'b0, r_phase} + LP_M_SUM;
    assign w_wrap       = (w_sum >= LP_L_SUM);
    assign w_phase_next = w_wrap ? (w_sum[AddrW-1:0] - LP_L_ADDR) : w_sum[AddrW-1:0];
    assign w_more_taps  = (({2'b00, r_coeff_addr} + LP_L_CMP) < LP_FL_CMP);
    assign w_req        = OutReq_i | r_req_latch;
    assign w_launch     = ((r_state == S_IDLE) && w_req && !r_pending) ||
                          ((r_state == S_FILL) && DataNd_i);
    // A fresh sample is the newest one; otherwise reuse the last written slot
    assign w_newest     = (r_state == S_FILL) ? r_addr_wr : (r_addr_wr - LP_ONE);

    assign DataReq_o    = (r_state == S_FILL);
    assign DataWe_o     = DataNd_i & DataReq_o;
    assign DataAddrWr_o = r_addr_wr;
    assign DataAddr_o   = r_data_addr;
    assign CoeffAddr_o  = r_coeff_addr;
    assign StartAcc_o   = r_start_sr[1];
    assign DataValid_o  = r_rdy_sr[1];
    assign Busy_o       = (r_state != S_IDLE);

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            r_state      <= S_IDLE;
            r_addr_wr    <= '0;
            r_data_addr  <= '0;
            r_coeff_addr <= '0;
            r_phase      <= '0;
            r_pending    <= 1'b1;
            r_req_latch  <= 1'b0;
            r_rdy        <= 1'b0;
            r_start_acc  <= 1'b0;
            r_start_sr   <= 2'b00;
            r_rdy_sr     <= 2'b00;
        end else begin
            r_start_acc <= 1'b0;
            r_rdy       <= 1'b0;
            r_start_sr  <= {r_start_sr[0], r_start_acc};
            r_rdy_sr    <= {r_rdy_sr[0], r_rdy};

            if (OutReq_i && (r_state != S_IDLE) && !r_req_latch) begin
                r_req_latch <= 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_req_latch <= 1'b0;
                        if (r_pending) begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (DataNd_i) begin
                        r_addr_wr <= r_addr_wr + LP_ONE;
                        r_pending <= 1'b0;
                    end
                end
                S_WORK: begin
                    if (w_more_taps) begin
                        r_data_addr  <= r_data_addr - LP_ONE;
                        r_coeff_addr <= r_coeff_addr + LP_L_ADDR;
                    end else begin
                        r_rdy   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Launch overrides the Fill-side pending clear with the phase-update result
            if (w_launch) begin
                r_data_addr  <= w_newest;
                r_coeff_addr <= r_phase;
                r_start_acc  <= 1'b1;
                r_state      <= S_WORK;
                r_phase      <= w_phase_next;
                r_pending    <= w_wrap;
            end
        end
    end

`ifdef FRAC_INTERP_OVERRUN_EN
    logic r_overrun;

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            r_overrun <= 1'b0;
        end else if (OutReq_i && r_req_latch && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
        end
    end

    assign Overrun_o = r_overrun;
`else
    assign Overrun_o = 1'b0;
`endif

endmodule

// File: tb/tb_frac_interp_ctrl.sv
// Self-checking bench for frac_interp_ctrl: timeline reference model plus directed literal checks.
module tb_frac_interp_ctrl;
    localparam int FL = 16;
    localparam int L  = 3;
    localparam int M  = 2;
    localparam int AW = 4;
`ifdef FRAC_INTERP_OVERRUN_EN
    localparam bit OVR = 1'b1;
`else
    localparam bit OVR = 1'b0;
`endif

    logic          Rst_i = 1'b1;
    logic          Clk_i = 1'b0;
    logic          OutReq_i = 1'b0;
    logic          DataNd_i = 1'b0;
    logic          DataReq_o, DataWe_o, StartAcc_o, DataValid_o, Busy_o, Overrun_o;
    logic [AW-1:0] DataAddrWr_o, DataAddr_o, CoeffAddr_o;

    int total = 0;
    int bad   = 0;

    frac_interp_ctrl #(
        .FilterLength(FL), .InterpolationK(L), .DecimationK(M), .AddrW(AW)
    ) dut (
        .Rst_i(Rst_i), .Clk_i(Clk_i), .OutReq_i(OutReq_i), .DataReq_o(DataReq_o),
        .DataNd_i(DataNd_i), .DataWe_o(DataWe_o), .DataAddrWr_o(DataAddrWr_o),
        .DataAddr_o(DataAddr_o), .CoeffAddr_o(CoeffAddr_o), .StartAcc_o(StartAcc_o),
        .DataValid_o(DataValid_o), .Busy_o(Busy_o), .Overrun_o(Overrun_o)
    );

    always #5 Clk_i = ~Clk_i;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: outputs as a function of the edge index since the last launch
    int m_cur, m_work_end, m_launch, m_T, m_ph_l, m_newest, m_phase, m_addr_wr;
    bit m_fill, m_pending, m_latch, m_ovr, m_launched;
    int q_start[$];
    int q_valid[$];

    always @(posedge Clk_i or posedge Rst_i) begin
        bit idle, req, go, was_fill;
        int newest;
        if (Rst_i) begin
            m_cur = 0; m_work_end = 0; m_launch = 0; m_T = 1; m_ph_l = 0; m_newest = 0;
            m_phase = 0; m_addr_wr = 0;
            m_fill = 0; m_pending = 1; m_latch = 0; m_ovr = 0; m_launched = 0;
            q_start.delete();
            q_valid.delete();
        end else begin
            was_fill = m_fill;
            idle     = !m_fill && !(m_cur < m_work_end);
            req      = OutReq_i || m_latch;
            go       = (idle && req && !m_pending) || (was_fill && DataNd_i);
            newest   = was_fill ? m_addr_wr : (m_addr_wr + 15) % 16;
            if (!idle && OutReq_i) begin
                if (m_latch && OVR) m_ovr = 1;
                m_latch = 1;
            end
            if (idle && req) begin
                m_latch = 0;
                if (m_pending) m_fill = 1;
            end
            if (was_fill && DataNd_i) begin
                m_addr_wr = (m_addr_wr + 1) % 16;
                m_fill    = 0;
            end
            m_cur++;
            if (go) begin
                m_launched = 1;
                m_launch   = m_cur;
                m_ph_l     = m_phase;
                m_newest   = newest;
                m_T        = (FL - m_phase + L - 1) / L;
                m_work_end = m_cur + m_T;
                q_start.push_back(m_cur + 2);
                q_valid.push_back(m_cur + m_T + 2);
                m_pending  = (m_phase + M >= L);
                m_phase    = (m_phase + M) % L;
            end
        end
    end

    always @(negedge Clk_i) begin
        int k, e_da, e_ca;
        bit e_st, e_dv;
        while (q_start.size() > 0 && q_start[0] < m_cur) void'(q_start.pop_front());
        while (q_valid.size() > 0 && q_valid[0] < m_cur) void'(q_valid.pop_front());
        e_st = (q_start.size() > 0) && (q_start[0] == m_cur);
        e_dv = (q_valid.size() > 0) && (q_valid[0] == m_cur);
        if (m_launched) begin
            k = m_cur - m_launch;
            if (k > m_T - 1) k = m_T - 1;
            e_da = (m_newest - k + 16) % 16;
            e_ca = m_ph_l + k * L;
        end else begin
            e_da = 0;
            e_ca = 0;
        end
        chk("busy",      int'(Busy_o),       int'(m_fill || (m_cur < m_work_end)));
        chk("datareq",   int'(DataReq_o),    int'(m_fill));
        chk("datawe",    int'(DataWe_o),     int'(m_fill && DataNd_i));
        chk("addrwr",    int'(DataAddrWr_o), m_addr_wr);
        chk("dataaddr",  int'(DataAddr_o),   e_da);
        chk("coeffaddr", int'(CoeffAddr_o),  e_ca);
        chk("startacc",  int'(StartAcc_o),   int'(e_st));
        chk("datavalid", int'(DataValid_o),  int'(e_dv));
        chk("overrun",   int'(Overrun_o),    int'(m_ovr));
    end

    task automatic tick();
        @(posedge Clk_i);
        #2;
    endtask

    task automatic do_reset();
        OutReq_i = 0;
        DataNd_i = 0;
        Rst_i    = 1;
        #1;
        chk("rst_busy",    int'(Busy_o),       0);
        chk("rst_addrwr",  int'(DataAddrWr_o), 0);
        chk("rst_overrun", int'(Overrun_o),    0);
        repeat (2) tick();
        Rst_i = 0;
        tick();
    endtask

    initial begin
        int exp_da[6];
        int vcount;
        exp_da = '{0, 15, 14, 13, 12, 11};
        #2;
        do_reset();

        // First output: fill then six taps from phase 0
        OutReq_i = 1; tick(); OutReq_i = 0;
        chk("t1_datareq", int'(DataReq_o), 1);
        DataNd_i = 1; #1;
        chk("t1_datawe", int'(DataWe_o), 1);
        chk("t1_addrwr", int'(DataAddrWr_o), 0);
        tick(); DataNd_i = 0;
        for (int i = 0; i < 6; i++) begin
            chk("t1_dataaddr", int'(DataAddr_o), exp_da[i]);
            chk("t1_coeff", int'(CoeffAddr_o), 3 * i);
            if (i == 2) chk("t1_startacc", int'(StartAcc_o), 1);
            tick();
        end
        repeat (2) tick();
        chk("t1_valid", int'(DataValid_o), 1);
        chk("t1_m_phase", m_phase, 2);
        chk("t1_m_pending", int'(m_pending), 0);

        // Second output: phase 2, no fill, reuse newest sample
        OutReq_i = 1; tick(); OutReq_i = 0;
        chk("t2_datareq", int'(DataReq_o), 0);
        chk("t2_dataaddr", int'(DataAddr_o), 0);
        chk("t2_coeff", int'(CoeffAddr_o), 2);
        for (int i = 1; i < 5; i++) begin
            tick();
            chk("t2_coeff", int'(CoeffAddr_o), 2 + 3 * i);
        end
        repeat (4) tick();
        chk("t2_m_phase", m_phase, 1);
        chk("t2_m_pending", int'(m_pending), 1);

        // Upstream always ready, request every 12 cycles: 4 samples consumed by 6 outputs
        DataNd_i = 1;
        for (int n = 0; n < 6; n++) begin
            OutReq_i = 1; tick(); OutReq_i = 0;
            repeat (11) tick();
        end
        DataNd_i = 0;
        chk("cont_addrwr", int'(DataAddrWr_o), 5);

        // Randomized traffic, occasional mid-operation reset
        for (int c = 0; c < 4000; c++) begin
            OutReq_i = ($urandom_range(0, 7) == 0);
            DataNd_i = ($urandom_range(0, 1) == 1);
            Rst_i    = ($urandom_range(0, 599) == 0);
            tick();
        end
        Rst_i = 0;
        OutReq_i = 0;
        DataNd_i = 0;
        repeat (12) tick();

        // Latched second request and dropped third
        do_reset();
        OutReq_i = 1; tick(); OutReq_i = 0;
        DataNd_i = 1; tick(); DataNd_i = 0;
        tick();
        OutReq_i = 1; tick(); OutReq_i = 0;
        tick();
        OutReq_i = 1; tick(); OutReq_i = 0;
        vcount = 0;
        for (int i = 0; i < 40; i++) begin
            vcount += int'(DataValid_o);
            tick();
        end
        chk("ovr_valids", vcount, 2);
        chk("ovr_flag", int'(Overrun_o), int'(OVR));

        // Reset during work aborts and re-arms the pending sample
        do_reset();
        OutReq_i = 1; tick(); OutReq_i = 0;
        DataNd_i = 1; tick(); DataNd_i = 0;
        repeat (3) tick();
        Rst_i = 1; #1;
        chk("abort_busy", int'(Busy_o), 0);
        chk("abort_coeff", int'(CoeffAddr_o), 0);
        tick(); Rst_i = 0; tick();
        chk("abort_m_phase", m_phase, 0);
        OutReq_i = 1; tick(); OutReq_i = 0;
        chk("abort_datareq", int'(DataReq_o), 1);
        DataNd_i = 1; tick(); DataNd_i = 0;
        repeat (12) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/frac_interp_ctrl.md
Name: frac_interp_ctrl

Overview:
- Output-driven control block for a single-MAC polyphase fractional interpolator (rate change InterpolationK/DecimationK, InterpolationK > DecimationK).
- The downstream consumer requests each output sample. The block pulls input samples from upstream only as the polyphase phase accumulator requires them.
- It drives the sample-buffer write/read addresses, the coefficient ROM address and the MAC start/valid strobes.
- It is the pull-side counterpart of the push-driven fractional decimator controller and shares the same MAC/RAM/ROM datapath conventions.

Parameters:
- FilterLength, 16: prototype filter taps; coefficient ROM depth.
- InterpolationK, 3: L; coefficient stride per MAC cycle and phase modulus.
- DecimationK, 2: M; phase increment per output. Must be < InterpolationK.
- AddrW, 4: data and coefficient address width. Data buffer is circular, depth 2^AddrW.

Ports:
- Rst_i  in  1  asynchronous reset, active-high.
- Clk_i  in  1  clock.
- OutReq_i  in  1  one-cycle strobe: consumer requests one output sample.
- DataReq_o  out  1  high while the block waits for an input sample.
- DataNd_i  in  1  input sample strobe. Accepted only in a cycle where DataReq_o=1.
- DataWe_o  out  1  write enable to the sample buffer; equals DataNd_i & DataReq_o.
- DataAddrWr_o  out  AddrW  sample buffer write address.
- DataAddr_o  out  AddrW  sample buffer read address.
- CoeffAddr_o  out  AddrW  coefficient ROM address.
- StartAcc_o  out  1  MAC accumulator clear/load, aligned with the first tap product.
- DataValid_o  out  1  one-cycle pulse: MAC output holds a finished sample.
- Busy_o  out  1  state != Idle.
- Overrun_o  out  1  sticky request-overrun flag (see Optional Feature).

Behaviour:
- Reset values:
  - state=Idle, addrWr=0, dataAddr=0, coeffAddr=0.
  - phase=0, pending=1 (one sample needed before the first output).
  - reqLatch=0, rdy=0, startAcc=0.
  - Both 2-bit delay shift registers = 0.
  - All outputs 0.
- Phase update happens once per launched output:
  - sum = phase + DecimationK.
  - If sum >= InterpolationK: phase <= sum - InterpolationK, pending <= 1.
  - Otherwise: phase <= sum, pending <= 0.
  - Width of sum is AddrW+1 bits, so no overflow.
- Launch action: dataAddr <= newest written address; coeffAddr <= phase; startAcc <= 1; state <= Work; apply the phase update.
- State Idle:
  - Request present means OutReq_i=1 or reqLatch=1. Clear reqLatch when it is consumed.
  - Request present and pending=0: launch with newest address = addrWr-1.
  - Request present and pending=1: state <= Fill.
  - No request: stay in Idle.
- State Fill:
  - DataReq_o=1.
  - On DataNd_i: write at addrWr, addrWr <= addrWr+1, pending <= 0, then launch in the same cycle with newest address = addrWr (pre-increment value).
- State Work:
  - While coeffAddr + InterpolationK < FilterLength: dataAddr <= dataAddr-1 (wraps mod 2^AddrW) and coeffAddr <= coeffAddr+InterpolationK.
  - Otherwise: rdy <= 1 for one cycle and state <= Idle.
  - Taps per output = ceil((FilterLength - phase) / InterpolationK).
- OutReq_i arriving while state is Fill or Work sets reqLatch. A request arriving while reqLatch=1 is dropped and handled as an overrun.
- DataNd_i while DataReq_o=0 is ignored: no write, no address change.
- addrWr wraps 2^AddrW-1 to 0. The buffer depth must be >= ceil(FilterLength/InterpolationK)+1. This is a static requirement and is not checked.
- Output latency:
  - StartAcc_o = startAcc delayed 2 clocks.
  - DataValid_o = rdy delayed 2 clocks. This covers the RAM/ROM read register plus the multiplier register.
- Rst_i mid-operation aborts immediately. All state, both shift registers, reqLatch and Overrun_o clear. No DataValid_o follows.
- Default/illegal state returns to Idle.

Optional Feature:
- Macro FRAC_INTERP_OVERRUN_EN.
- Defined: Overrun_o is set when OutReq_i=1 while reqLatch=1 and state != Idle. It stays set until reset; the dropped request is discarded.
- Undefined: the overrun logic is absent, Overrun_o is tied 0, and extra requests are silently dropped.

Test Plan:
- Reset, then OutReq_i pulse → Fill with DataReq_o=1. DataNd_i one cycle later → DataWe_o=1 at DataAddrWr_o=0. Then CoeffAddr_o = 0,3,6,9,12,15 with DataAddr_o = 0,15,14,13,12,11. StartAcc_o occurs 2 clocks after the first tap; DataValid_o occurs 2 clocks after the cycle following tap 15.
- Continuous OutReq_i every 12 cycles with upstream always supplying → phase sequence 0,2,1,0,… and tap counts 6,5,5. DataReq_o is asserted for outputs 1, 3 and 4 but not output 2: 3 outputs per 2 inputs.
- Output 2 (phase 2) → no Fill. The launch uses DataAddr_o = addrWr-1 and coeffs 2,5,8,11,14.
- Write 17 samples across outputs → DataAddrWr_o wraps 15→0. Read addresses decrement through 0→15 correctly.
- Second OutReq_i during Work → served right after DataValid_o. A third OutReq_i during Work, with the macro defined → Overrun_o=1 and only 2 DataValid_o pulses; with the macro undefined → Overrun_o=0.
- Assert Rst_i during Work at tap 3 → all outputs 0 and phase=0. The next OutReq_i requires a new sample (pending=1).
